// File: rtl/dna_port_ctrl_pkg.sv
// Shared types and constants for the device-DNA readout controller.
package dna_pkg;

  localparam int DNA_WIDTH = 57;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } dna_state_t;

  // Reference ID used by simulation models of the primitive.
  localparam logic [DNA_WIDTH-1:0] DNA_SIM_VALUE = 57'h0AAAAAAAAAAAAAA;

endpackage

// File: rtl/dna_port_ctrl_if.sv
// Request/result handshake between an ID consumer and dna_port_ctrl.
// start is a one-cycle request; busy covers acceptance..dna_valid rise;
// dna_value/dna_mismatch are meaningful only while dna_valid is high.
interface dna_port_ctrl_if;
  import dna_pkg::*;

  logic                 start;
  logic                 busy;
  logic                 dna_valid;
  logic [DNA_WIDTH-1:0] dna_value;
  logic                 dna_mismatch;

  modport master (
    output start,
    input  busy,
    input  dna_valid,
    input  dna_value,
    input  dna_mismatch
  );

  modport slave (
    input  start,
    output busy,
    output dna_valid,
    output dna_value,
    output dna_mismatch
  );

endinterface

// File: rtl/dna_port_ctrl_clk_gen.sv
// Registered DNA clock divider: dna_clk toggles every CLK_DIV clk cycles while
// run is high; rise_evt/fall_evt flag the clk cycle whose edge makes the toggle.
module dna_clk_gen #(
  parameter int CLK_DIV = 8
) (
  input  logic clk,
  input  logic reset_n,
  input  logic run,
  output logic dna_clk,
  output logic rise_evt,
  output logic fall_evt
);

  logic [7:0] div_cnt;
  logic       wrap;

  assign wrap     = run && (div_cnt == 8'(CLK_DIV - 1));
  assign rise_evt = wrap && !dna_clk;
  assign fall_evt = wrap && dna_clk;

  always_ff @(posedge clk) begin
    if (!reset_n || !run) begin
      div_cnt <= 8'd0;
      dna_clk <= 1'b0;
    end else if (wrap) begin
      div_cnt <= 8'd0;
      dna_clk <= ~dna_clk;
    end else begin
      div_cnt <= div_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/dna_port_ctrl.sv
// Start/valid sequencer for the DNA_PORT primitive. Define DNA_VERIFY_EN to
// perform a second verify read per request and flag any disagreement.
module dna_port_ctrl
  import dna_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  dna_port_ctrl_if.slave io,
  output logic       dna_clk,
  output logic       dna_read,
  output logic       dna_shift,
  output logic       dna_din,
  input  logic       dna_dout,
  output dna_state_t dbg_state
);

  dna_state_t           state;
  logic [5:0]           bit_cnt;
  logic [DNA_WIDTH-1:0] shadow;
  logic [DNA_WIDTH-1:0] shadow_nxt;
  logic                 run;
  logic                 rise_evt;
  logic                 fall_evt;
`ifdef DNA_VERIFY_EN
  logic                 pass2;
  logic [DNA_WIDTH-1:0] first_val;
`endif

  assign run        = (state == LOAD) || (state == SHIFT);
  assign shadow_nxt = {shadow[DNA_WIDTH-2:0], dna_dout};
  assign dna_din    = 1'b0;
  assign dbg_state  = state;

  dna_clk_gen #(.CLK_DIV(CLK_DIV)) u_clk_gen (
    .clk      (clk),
    .reset_n  (reset_n),
    .run      (run),
    .dna_clk  (dna_clk),
    .rise_evt (rise_evt),
    .fall_evt (fall_evt)
  );

  // Controls change and DOUT is sampled only on fall events, so READ/SHIFT
  // are settled half a DNA period before every rising edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state           <= IDLE;
      bit_cnt         <= 6'd0;
      shadow          <= '0;
      dna_read        <= 1'b0;
      dna_shift       <= 1'b0;
      io.busy         <= 1'b0;
      io.dna_valid    <= 1'b0;
      io.dna_value    <= '0;
      io.dna_mismatch <= 1'b0;
`ifdef DNA_VERIFY_EN
      pass2           <= 1'b0;
      first_val       <= '0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (io.busy) begin
            // First cycle in DONE: publish the completed result.
            io.busy      <= 1'b0;
            io.dna_valid <= 1'b1;
`ifdef DNA_VERIFY_EN
            io.dna_value    <= first_val;
            io.dna_mismatch <= (first_val != shadow);
`else
            io.dna_value    <= shadow;
`endif
          end else if (io.start) begin
            state        <= LOAD;
            dna_read     <= 1'b1;
            dna_shift    <= 1'b0;
            io.busy      <= 1'b1;
            io.dna_valid <= 1'b0;
            bit_cnt      <= 6'd0;
            shadow       <= '0;
`ifdef DNA_VERIFY_EN
            pass2        <= 1'b0;
`endif
          end
        end
        LOAD: begin
          if (fall_evt) begin
            dna_read  <= 1'b0;
            dna_shift <= 1'b1;
            shadow    <= shadow_nxt;
            bit_cnt   <= 6'd1;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (fall_evt) begin
            shadow  <= shadow_nxt;
            bit_cnt <= bit_cnt + 6'd1;
            if (bit_cnt == 6'(DNA_WIDTH - 1)) begin
              dna_shift <= 1'b0;
`ifdef DNA_VERIFY_EN
              if (!pass2) begin
                // Divider keeps running: the verify pass starts seamlessly.
                pass2     <= 1'b1;
                first_val <= shadow_nxt;
                dna_read  <= 1'b1;
                bit_cnt   <= 6'd0;
                state     <= LOAD;
              end else begin
                state <= DONE;
              end
`else
              state <= DONE;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_port_ctrl.sv
// Directed bench for dna_port_ctrl with a behavioural DNA_PORT model.
// Follows DNA_VERIFY_EN for expected latency and mismatch behaviour.
module tb_dna_port_ctrl;
  import dna_pkg::*;

  localparam int CLK_DIV = 8;
`ifdef DNA_VERIFY_EN
  localparam int LAT   = 228 * CLK_DIV + 1;
  localparam int RISES = 114;
  localparam int READS = 2;
`else
  localparam int LAT   = 114 * CLK_DIV + 1;
  localparam int RISES = 57;
  localparam int READS = 1;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       dna_clk, dna_read, dna_shift, dna_din, dna_dout;
  dna_state_t dbg_state;

  dna_port_ctrl_if io ();

  dna_port_ctrl #(.CLK_DIV(CLK_DIV)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .io        (io),
    .dna_clk   (dna_clk),
    .dna_read  (dna_read),
    .dna_shift (dna_shift),
    .dna_din   (dna_din),
    .dna_dout  (dna_dout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // DNA_PORT model: READ loads the ID on a rising CLK, SHIFT shifts in DIN.
  logic [56:0] model_val = DNA_SIM_VALUE;
  logic [56:0] model_sreg = '0;
  always @(posedge dna_clk) begin
    if (dna_read) model_sreg <= model_val;
    else if (dna_shift) model_sreg <= {model_sreg[55:0], dna_din};
  end
  assign dna_dout = model_sreg[56];

  int n_checks = 0;
  int n_pass   = 0;

  // Protocol monitor
  logic mon_en = 1'b0;
  int   mon_err = 0, rise_cnt = 0, read_rise_cnt = 0, half_cnt = 0;
  logic p_clk, p_read, p_shift, p_busy;
  always @(negedge clk) begin
    if (mon_en) begin
      if (dna_read && dna_shift) mon_err++;
      if ((dna_read !== p_read || dna_shift !== p_shift) &&
          !(p_clk && !dna_clk) && !(io.busy && !p_busy)) mon_err++;
      if (dna_clk !== p_clk) begin
        if (half_cnt != CLK_DIV) mon_err++;
        half_cnt = 1;
        if (dna_clk) begin
          rise_cnt++;
          if (dna_read) read_rise_cnt++;
        end
      end else if (io.busy) half_cnt++;
      else half_cnt = 0;
    end else begin
      half_cnt = 0;
    end
    p_clk   = dna_clk;
    p_read  = dna_read;
    p_shift = dna_shift;
    p_busy  = io.busy;
  end

  // Issue start at cycle 0 and wait (bounded) for dna_valid.
  task automatic run_read(input int p1, input int p2, input int sw_at,
                          input logic [56:0] sw_val, output int lat,
                          output logic v0, output logic stable_ok);
    logic [56:0] val0;
    int cyc;
    rise_cnt = 0; read_rise_cnt = 0; mon_err = 0;
    stable_ok = 1'b1;
    val0 = io.dna_value;
    @(posedge clk); #1;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    v0 = io.dna_valid;
    cyc = 0;
    lat = -1;
    while (cyc < 4000) begin
      io.start = ((cyc + 1) == p1) || ((cyc + 1) == p2);
      @(posedge clk); #1;
      cyc++;
      io.start = 1'b0;
      if (cyc == sw_at) model_val = sw_val;
      if (io.busy && io.dna_value !== val0) stable_ok = 1'b0;
      if (io.dna_valid) begin
        lat = cyc;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset_n  = 1'b0;
    io.start = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", io.busy); else n_pass++;
    n_checks++; if (io.dna_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", io.dna_valid); else n_pass++;
    n_checks++; if (io.dna_value !== 57'd0) $display("FAIL reset_value got %h exp 0", io.dna_value); else n_pass++;
    n_checks++; if (io.dna_mismatch !== 1'b0) $display("FAIL reset_mismatch got %b exp 0", io.dna_mismatch); else n_pass++;
    n_checks++; if (dna_clk !== 1'b0) $display("FAIL reset_dna_clk got %b exp 0", dna_clk); else n_pass++;
    n_checks++; if (dna_read !== 1'b0 || dna_shift !== 1'b0)
      $display("FAIL reset_read_shift got %b%b exp 00", dna_read, dna_shift); else n_pass++;
    n_checks++; if (dna_din !== 1'b0) $display("FAIL reset_din got %b exp 0", dna_din); else n_pass++;
    n_checks++; if (dbg_state !== IDLE) $display("FAIL reset_state got %0d exp 0", dbg_state); else n_pass++;
    io.start = 1'b0;
    reset_n  = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL idle_no_start got busy %b exp 0", io.busy); else n_pass++;
    mon_en = 1'b1;
  endtask

  task automatic test_basic_read();
    int lat; logic v0, st;
    model_val = DNA_SIM_VALUE;
    run_read(0, 0, 0, '0, lat, v0, st);
    n_checks++; if (lat != LAT) $display("FAIL basic_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_checks++; if (io.busy !== 1'b0) $display("FAIL basic_busy got %b exp 0", io.busy); else n_pass++;
    n_checks++; if (io.dna_value !== DNA_SIM_VALUE)
      $display("FAIL basic_value got %h exp %h", io.dna_value, DNA_SIM_VALUE); else n_pass++;
    n_checks++; if (rise_cnt != RISES) $display("FAIL basic_rises got %0d exp %0d", rise_cnt, RISES); else n_pass++;
    n_checks++; if (read_rise_cnt != READS)
      $display("FAIL basic_read_rises got %0d exp %0d", read_rise_cnt, READS); else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL basic_protocol got %0d errors exp 0", mon_err); else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL basic_value_stable got %b exp 1", st); else n_pass++;
    n_checks++; if (io.dna_mismatch !== 1'b0) $display("FAIL basic_mismatch got %b exp 0", io.dna_mismatch); else n_pass++;
  endtask

  task automatic test_start_while_busy();
    int lat; logic v0, st;
    run_read(10, 500, 0, '0, lat, v0, st);
    n_checks++; if (lat != LAT) $display("FAIL busy_start_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_checks++; if (rise_cnt != RISES) $display("FAIL busy_start_rises got %0d exp %0d", rise_cnt, RISES); else n_pass++;
    n_checks++; if (mon_err != 0) $display("FAIL busy_start_protocol got %0d errors exp 0", mon_err); else n_pass++;
    repeat (3 * CLK_DIV) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== DONE || io.busy !== 1'b0)
      $display("FAIL busy_start_one_read got state %0d busy %b exp 3/0", dbg_state, io.busy); else n_pass++;
  endtask

  task automatic test_reset_mid_read();
    int lat; logic v0, st;
    mon_en = 1'b0;
    @(posedge clk); #1;
    io.start = 1'b1;
    @(posedge clk); #1;
    io.start = 1'b0;
    repeat (399) @(posedge clk);
    #1;
    n_checks++; if (dbg_state !== SHIFT) $display("FAIL midreset_pre_state got %0d exp 2", dbg_state); else n_pass++;
    reset_n = 1'b0;
    @(posedge clk); #1;
    n_checks++; if ({io.busy, io.dna_valid, io.dna_mismatch, dna_clk, dna_read, dna_shift} !== 6'b0)
      $display("FAIL midreset_outputs got %b exp 000000",
               {io.busy, io.dna_valid, io.dna_mismatch, dna_clk, dna_read, dna_shift}); else n_pass++;
    n_checks++; if (io.dna_value !== 57'd0) $display("FAIL midreset_value got %h exp 0", io.dna_value); else n_pass++;
    reset_n = 1'b1;
    @(posedge clk); #1;
    mon_en = 1'b1;
    run_read(0, 0, 0, '0, lat, v0, st);
    n_checks++; if (lat != LAT) $display("FAIL midreset_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_checks++; if (io.dna_value !== DNA_SIM_VALUE)
      $display("FAIL midreset_value_after got %h exp %h", io.dna_value, DNA_SIM_VALUE); else n_pass++;
  endtask

  task automatic test_reread();
    int lat; logic v0, st;
    model_val = 57'h1FFFFFFFFFFFFFF;
    run_read(0, 0, 0, '0, lat, v0, st);
    n_checks++; if (io.dna_value !== 57'h1FFFFFFFFFFFFFF)
      $display("FAIL reread_first got %h exp 1ffffffffffffff", io.dna_value); else n_pass++;
    n_checks++; if (io.dna_valid !== 1'b1) $display("FAIL reread_valid_before got %b exp 1", io.dna_valid); else n_pass++;
    model_val = 57'h000000000000001;
    run_read(0, 0, 0, '0, lat, v0, st);
    n_checks++; if (v0 !== 1'b0) $display("FAIL reread_valid_drop got %b exp 0", v0); else n_pass++;
    n_checks++; if (lat != LAT) $display("FAIL reread_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_checks++; if (io.dna_value !== 57'h000000000000001)
      $display("FAIL reread_second got %h exp 000000000000001", io.dna_value); else n_pass++;
    n_checks++; if (st !== 1'b1) $display("FAIL reread_value_stable got %b exp 1", st); else n_pass++;
  endtask

  task automatic test_mismatch();
    int lat; logic v0, st;
    logic exp_mm;
`ifdef DNA_VERIFY_EN
    exp_mm = 1'b1;
`else
    exp_mm = 1'b0;
`endif
    model_val = DNA_SIM_VALUE;
    // Changes the model after the first pass but before the verify load.
    run_read(0, 0, 915, 57'h155555555555555, lat, v0, st);
    n_checks++; if (lat != LAT) $display("FAIL mismatch_latency got %0d exp %0d", lat, LAT); else n_pass++;
    n_checks++; if (io.dna_mismatch !== exp_mm)
      $display("FAIL mismatch_flag got %b exp %b", io.dna_mismatch, exp_mm); else n_pass++;
    n_checks++; if (io.dna_value !== DNA_SIM_VALUE)
      $display("FAIL mismatch_value got %h exp %h", io.dna_value, DNA_SIM_VALUE); else n_pass++;
    model_val = 57'h123456789ABCDEF;
    run_read(0, 0, 0, '0, lat, v0, st);
    n_checks++; if (io.dna_mismatch !== 1'b0)
      $display("FAIL const_mismatch_flag got %b exp 0", io.dna_mismatch); else n_pass++;
    n_checks++; if (io.dna_value !== 57'h123456789ABCDEF)
      $display("FAIL const_value got %h exp 123456789abcdef", io.dna_value); else n_pass++;
  endtask

  initial begin
    io.start = 1'b0;
    test_reset();
    test_basic_read();
    test_start_while_busy();
    test_reset_mid_read();
    test_reread();
    test_mismatch();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
